// File: rtl/program_loader.sv
// Serial byte loader: length byte, 3-byte little-endian words written to instruction memory, XOR checksum byte.
// One memory write per 3 accepted bytes plus one cycle; byte_ready gates every transfer and the loader waits indefinitely.
module program_loader #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst_n,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [7:0]               r_len;
    logic [7:0]               r_b0;
    logic [7:0]               r_b1;
    logic [7:0]               r_csum;
    logic [ADDRESS_WIDTH:0]   r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;

    logic                     w_accept;
    logic                     w_start_go;
    logic                     w_len_bad;
    logic                     w_b2_bad;
    logic                     w_last_word;
    logic [ADDRESS_WIDTH:0]   w_cnt_inc;
    logic [DATA_WIDTH-1:0]    w_word;

    assign w_accept    = byte_valid & byte_ready;
    assign w_start_go  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    assign w_len_bad   = (byte_data == 8'd0) || (int'(byte_data) > MEM_SIZE);
    // Third byte may only carry the bits that fit above bit 15 of the word.
    assign w_b2_bad    = |(byte_data >> (DATA_WIDTH - 16));
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_last_word = (int'(w_cnt_inc) == int'(r_len));
    assign w_word      = {byte_data[DATA_WIDTH-17:0], r_b1, r_b0};

    assign imem_we    = (r_state == S_WRITE);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign cpu_rst_n  = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                byte_ready = 1'b1;
                if (w_accept) w_next = w_len_bad ? S_ERR : S_B0;
            end
            S_B0: begin
                byte_ready = 1'b1;
                if (w_accept) w_next = S_B1;
            end
            S_B1: begin
                byte_ready = 1'b1;
                if (w_accept) w_next = S_B2;
            end
            S_B2: begin
                byte_ready = 1'b1;
                if (w_accept) w_next = w_b2_bad ? S_ERR : S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last_word ? S_CHK : S_B0;
            end
            S_CHK: begin
                byte_ready = 1'b1;
                if (w_accept) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_csum  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_start_go) begin
                r_cnt  <= '0;
                r_csum <= '0;
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN: r_len <= byte_data;
                    S_B0: begin
                        r_b0   <= byte_data;
                        r_csum <= r_csum ^ byte_data;
                    end
                    S_B1: begin
                        r_b1   <= byte_data;
                        r_csum <= r_csum ^ byte_data;
                    end
                    S_B2: begin
                        r_csum <= r_csum ^ byte_data;
                        // Address/data latch on entry to WRITE and then hold until the next word.
                        if (!w_b2_bad) begin
                            r_addr  <= r_cnt[ADDRESS_WIDTH-1:0];
                            r_wdata <= w_word;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a load-level model predicts writes and outcome, a per-cycle monitor compares.
module tb_program_loader;
    localparam int DW = 20;
    localparam int AW = 8;
    localparam int MS = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_rst_n;
    logic          done;
    logic          error;

    program_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         log_addr[$];
    int         log_data[$];
    int         m_last_addr = 0;
    int         m_last_data = 0;
    bit         m_done;
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Predict the whole load from the byte stream; trims tx_q to what the loader will consume.
    task automatic model_load();
        int         n;
        int         used;
        int         x;
        bit         err;
        logic [7:0] b0, b1, b2;
        n    = int'(tx_q[0]);
        used = 1;
        x    = 0;
        err  = 1'b0;
        if (n == 0 || n > MS) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < n && !err; i++) begin
                b0 = tx_q[used];
                b1 = tx_q[used+1];
                b2 = tx_q[used+2];
                used += 3;
                x = x ^ int'(b0) ^ int'(b1) ^ int'(b2);
                if (int'(b2) >= (1 << (DW - 16))) begin
                    err = 1'b1;
                end else begin
                    exp_addr.push_back(i);
                    exp_data.push_back(int'(b2) * 65536 + int'(b1) * 256 + int'(b0));
                end
            end
        end
        if (!err) begin
            err = (int'(tx_q[used]) != x);
            used++;
        end
        m_err  = err;
        m_done = !err;
        while (tx_q.size() > used) void'(tx_q.pop_back());
    endtask

    task automatic send_all(input bit gaps, input bit inj_start);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        while (idx < tx_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            start = inj_start && (idx == 2);
            if (gaps && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = tx_q[idx];
                if (byte_ready) idx++;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        if (guard >= 2000) chk("send_timeout", idx, tx_q.size());
    endtask

    task automatic run_load(input string tag, input bit gaps, input bit inj_start);
        int k;
        log_addr.delete();
        log_data.delete();
        model_load();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        send_all(gaps, inj_start);
        k = 0;
        while (!(done || error) && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_error"}, error, m_err);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, m_done);
        chk({tag, "_pending_writes"}, exp_addr.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                chk("ready_in_write", byte_ready, 1'b0);
                log_addr.push_back(int'(imem_addr));
                log_data.push_back(int'(imem_wdata));
                if (exp_addr.size() > 0) begin
                    chk("write_addr", imem_addr, exp_addr[0]);
                    chk("write_data", imem_wdata, exp_data[0]);
                    m_last_addr = exp_addr.pop_front();
                    m_last_data = exp_data.pop_front();
                end else begin
                    chk("unexpected_write", imem_we, 1'b0);
                    m_last_addr = int'(imem_addr);
                    m_last_data = int'(imem_wdata);
                end
            end else begin
                chk("addr_hold", imem_addr, m_last_addr);
                chk("wdata_hold", imem_wdata, m_last_data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 1'b0);
        chk({tag, "_imem_we"}, imem_we, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word image with good checksum.
        tx_q = {8'h02, 8'h21, 8'h43, 8'h05, 8'h0A, 8'h00, 8'h00, 8'h6D};
        run_load("t1", 1'b0, 1'b0);
        chk("t1_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("t1_a0", log_addr[0], 0);
            chk("t1_d0", log_data[0], 'h54321);
            chk("t1_a1", log_addr[1], 1);
            chk("t1_d1", log_data[1], 'h0000A);
        end
        chk("t1_done_lit", done, 1'b1);

        // Bad checksum after one written word.
        tx_q = {8'h01, 8'h01, 8'h02, 8'h03, 8'hFF};
        run_load("t2", 1'b1, 1'b0);
        chk("t2_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) chk("t2_d0", log_data[0], 'h30201);
        chk("t2_err_lit", error, 1'b1);

        // Zero length, then a good one-word image from ERR.
        tx_q = {8'h00};
        run_load("t3a", 1'b0, 1'b0);
        chk("t3a_nwr", log_addr.size(), 0);
        tx_q = {8'h01, 8'h11, 8'h22, 8'h0F, 8'h3C};
        run_load("t3b", 1'b1, 1'b0);
        chk("t3b_done_lit", done, 1'b1);
        if (log_data.size() == 1) chk("t3b_d0", log_data[0], 'hF2211);

        // Third byte carries a bit that does not fit the word.
        tx_q = {8'h01, 8'h00, 8'h00, 8'h10};
        run_load("t4", 1'b0, 1'b0);
        chk("t4_nwr", log_addr.size(), 0);
        chk("t4_err_lit", error, 1'b1);

        // Reset mid-load after two data bytes, then a full load.
        tx_q = {8'h03, 8'h10, 8'h20};
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        send_all(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        m_last_addr = 0;
        m_last_data = 0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        #2 rst = 1'b0;
        tx_q = {8'h03, 8'h10, 8'h20, 8'h01, 8'h30, 8'h40, 8'h02, 8'h50, 8'h60, 8'h03, 8'h70};
        run_load("t5", 1'b1, 1'b0);
        chk("t5_nwr", log_addr.size(), 3);

        // Start pulsed while the second byte of the first word is awaited.
        tx_q = {8'h02, 8'hAA, 8'hBB, 8'h0C, 8'h01, 8'h02, 8'h03, 8'h1D};
        run_load("t6", 1'b0, 1'b1);
        chk("t6_done_lit", done, 1'b1);
        chk("t6_nwr", log_addr.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
